mm_uart_sched: RTL and testbench
================================

Name: mm_uart_sched

Overview:
Round-robin scheduler that shares the single UART transmitter among the multimeter result channels (ADC, FIR avg, RMS, IIR avg). It latches the newest BCD value per channel, arbitrates between pending channels, formats the 13-char message ("Vxxx: d.dddV\r"), and sequences the transmitter's update/busy handshake. An inter-message gap enforces a minimum spacing between messages. It sits between mm_result/filter outputs and uart_top.

Parameters:
REQ_NR, 4, number of requesting channels (2..8)
CHAR_NR, 13, characters per message (fixed format, must be 13)
GAP_CYC, 100000, idle clock cycles after each message before the next grant (>=1)
START_TO, 8, cycles to wait for uart_busy_i to rise before a send is treated as done

Ports:
clk  in  1  system clock 100 MHz
rst_n  in  1  reset, asynchronous, active-low
clr_i  in  1  synchronous clear
en_i  in  1  enables new grants
din_bcd_i  in  REQ_NR*16  per-channel 4-digit BCD; channel k occupies [16k+15:16k]
din_update_i  in  REQ_NR  per-channel one-cycle update strobe
uart_busy_i  in  1  transmitter busy
char_array_o  out  CHAR_NR*8  message; first char in MSBs
char_array_update_o  out  1  one-cycle send strobe to the UART
grant_o  out  REQ_NR  one-hot, channel currently being sent
busy_o  out  1  high in any state other than IDLE

Behaviour:
- Reset/clr: state IDLE, pending all 0, RR pointer 0, gap counter 0, all outputs 0; char_array_o = all 0.
- Capture: din_update_i[k] -> latch din_bcd_i[k] into buf[k], set pend[k], on the next edge. A newer update overwrites buf[k] (latest wins).
- States:
  IDLE: if en_i && |pend -> pick the first pending channel at or after the RR pointer (wrapping) -> LOAD. Register char_array_o from buf[k]. Set grant_o = one-hot k. Clear pend[k]. Set pointer = k+1 mod REQ_NR.
  LOAD: char_array_update_o=1 for exactly this cycle -> WAIT_START.
  WAIT_START: uart_busy_i=1 -> WAIT_DONE; START_TO cycles without busy -> GAP (send treated as done).
  WAIT_DONE: uart_busy_i=0 -> GAP.
  GAP: count GAP_CYC cycles, then grant_o=0 -> IDLE.
- Latency: a pending channel in IDLE gets its strobe 2 cycles after the IDLE decision edge (decision edge, then LOAD cycle).
- char_array_o and grant_o stay stable from LOAD until GAP exits.
- Format: prefix (6 chars, from PREFIX_LUT[k]) + ascii(d3) + "." + ascii(d2) + ascii(d1) + ascii(d0) + "V" + 8'h0D. A non-BCD nibble (>9) is sent as "?".
- Update and grant to the same channel in the same cycle: the old buf value is sent; the new value is latched and pend[k] stays set.
- en_i low: no new grants. A transfer already in progress finishes normally.
- clr_i in any state: abort immediately to IDLE. No strobe is issued that cycle.
- Wrap: pointer REQ_NR-1 -> 0.

Optional Feature:
MM_UART_SCHED_DROP_CNT_EN
- With it: extra output drop_cnt_o [15:0]. It increments (saturating at 16'hFFFF) whenever an update overwrites a buf[k] whose pend[k] is still set. It is cleared by reset or clr_i.
- Without it: the port and counter are absent and behaviour is otherwise identical.

Decomposition:
- mm_pkg:
  - sched_state_t enum (IDLE, LOAD, WAIT_START, WAIT_DONE, GAP)
  - MM_CHAR_NR=13
  - PREFIX_LUT ("Vadc: ","Vfir: ","Vrms: ","Viir: ")
  - num2ascii function
- Sub-module ste_rr_arbiter: parameter REQ_NR. Inputs: req vector, pointer. Output: one-hot grant plus valid. Purely combinational, reusable.

Test Plan:
- Single channel: din_update_i=4'b0001, BCD 16'h1234 -> one strobe, char_array_o="Vadc: 1.234V\r", grant_o=0001. Hold uart_busy_i high 50 cycles -> 100000-cycle gap -> IDLE.
- All four channels updated in the same cycle with values 1111/2222/3333/4444 -> sent in order ch0, ch1, ch2, ch3. Each strobe is separated by busy time plus GAP_CYC. Next round starts at ch0 after pointer wrap.
- Overwrite: ch2 updated with 0500 then 0600 while ch0 is sending -> ch2 sends "Vrms: 0.600V\r" once. drop_cnt_o=1 when the macro is defined.
- Busy never rises: after strobe uart_busy_i stays 0 -> GAP entered after START_TO=8 cycles, no hang.
- clr_i asserted in WAIT_DONE -> next cycle IDLE, pend=0, grant_o=0, no further strobe until a new update arrives.
- en_i=0 with ch1 pending -> no strobe. Raise en_i -> strobe 2 cycles later with ch1 data.

Source files
------------

// File: rtl/mm_pkg.sv
// rtl/mm_pkg.sv - shared types, constants and message formatting for the multimeter UART scheduler
package mm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT_START,
    WAIT_DONE,
    GAP
  } sched_state_t;

  localparam int MM_CHAR_NR = 13;

  // Entries 4..7 only matter when more than four channels are configured
  localparam logic [47:0] PREFIX_LUT [8] = '{
    "Vadc: ", "Vfir: ", "Vrms: ", "Viir: ",
    "Vch4: ", "Vch5: ", "Vch6: ", "Vch7: "
  };

  function automatic logic [7:0] num2ascii(input logic [3:0] n);
    return (n <= 4'd9) ? (8'h30 + {4'h0, n}) : 8'h3F;
  endfunction

  function automatic logic [MM_CHAR_NR*8-1:0] format_msg(input logic [2:0] ch,
                                                         input logic [15:0] bcd);
    return {PREFIX_LUT[ch], num2ascii(bcd[15:12]), 8'h2E, num2ascii(bcd[11:8]),
            num2ascii(bcd[7:4]), num2ascii(bcd[3:0]), 8'h56, 8'h0D};
  endfunction

endpackage

// File: rtl/ste_rr_arbiter.sv
// rtl/ste_rr_arbiter.sv - combinational round-robin arbiter: first request at or after ptr, wrapping
module ste_rr_arbiter #(
  parameter int REQ_NR = 4,
  localparam int PW = (REQ_NR > 1) ? $clog2(REQ_NR) : 1
) (
  input  logic [REQ_NR-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [REQ_NR-1:0] gnt,
  output logic              valid
);

  always_comb begin
    int j;
    gnt   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < REQ_NR; i++) begin
      j = int'(ptr) + i;
      if (j >= REQ_NR) j = j - REQ_NR;
      if (!valid && req[j[PW-1:0]]) begin
        gnt[j[PW-1:0]] = 1'b1;
        valid          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_uart_sched.sv
// rtl/mm_uart_sched.sv - round-robin sharing of one UART among multimeter result channels
// Optional drop counter output enabled by MM_UART_SCHED_DROP_CNT_EN.
module mm_uart_sched
  import mm_pkg::*;
#(
  parameter int REQ_NR   = 4,
  parameter int CHAR_NR  = MM_CHAR_NR,
  parameter int GAP_CYC  = 100000,
  parameter int START_TO = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clr_i,
  input  logic                   en_i,
  input  logic [REQ_NR*16-1:0]   din_bcd_i,
  input  logic [REQ_NR-1:0]      din_update_i,
  input  logic                   uart_busy_i,
  output logic [CHAR_NR*8-1:0]   char_array_o,
  output logic                   char_array_update_o,
  output logic [REQ_NR-1:0]      grant_o,
  output logic                   busy_o
`ifdef MM_UART_SCHED_DROP_CNT_EN
  ,
  output logic [15:0]            drop_cnt_o
`endif
);

  localparam int PW      = (REQ_NR > 1) ? $clog2(REQ_NR) : 1;
  localparam int CNT_MAX = (GAP_CYC > START_TO) ? GAP_CYC : START_TO;
  localparam int CW      = $clog2(CNT_MAX + 1);

  sched_state_t              state, state_nxt;
  logic [REQ_NR-1:0][15:0]   bcd_buf;
  logic [REQ_NR-1:0]         pend;
  logic [PW-1:0]             rr_ptr;
  logic [CW-1:0]             cnt;
  logic [REQ_NR-1:0]         arb_gnt;
  logic                      arb_valid;
  logic [PW-1:0]             gnt_idx;
  logic                      take;
  logic                      start_to_hit;
  logic                      gap_done;

  ste_rr_arbiter #(.REQ_NR(REQ_NR)) u_arb (
    .req   (pend),
    .ptr   (rr_ptr),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < REQ_NR; i++) begin
      if (arb_gnt[i]) gnt_idx = PW'(i);
    end
  end

  assign take         = (state == IDLE) && en_i && arb_valid;
  assign start_to_hit = (cnt == CW'(START_TO - 1));
  assign gap_done     = (cnt == CW'(GAP_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:       if (take) state_nxt = LOAD;
      LOAD:       state_nxt = WAIT_START;
      WAIT_START: begin
        if (uart_busy_i)       state_nxt = WAIT_DONE;
        else if (start_to_hit) state_nxt = GAP;
      end
      WAIT_DONE:  if (!uart_busy_i) state_nxt = GAP;
      GAP:        if (gap_done) state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
    if (clr_i) state_nxt = IDLE;
  end

  // Strobe is gated by clr_i so an abort in LOAD never reaches the UART
  assign char_array_update_o = (state == LOAD) && !clr_i;
  assign busy_o              = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_buf      <= '0;
      pend         <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
      grant_o      <= '0;
      char_array_o <= '0;
    end else if (clr_i) begin
      bcd_buf      <= '0;
      pend         <= '0;
      rr_ptr       <= '0;
      cnt          <= '0;
      grant_o      <= '0;
      char_array_o <= '0;
    end else begin
      for (int k = 0; k < REQ_NR; k++) begin
        if (din_update_i[k]) bcd_buf[k] <= din_bcd_i[16*k +: 16];
      end
      // A same-cycle update re-arms pend for the channel being granted
      pend <= (pend & ~(take ? arb_gnt : '0)) | din_update_i;
      if (take) begin
        char_array_o <= format_msg(3'(gnt_idx), bcd_buf[gnt_idx]);
        grant_o      <= arb_gnt;
        rr_ptr       <= (gnt_idx == PW'(REQ_NR - 1)) ? '0 : gnt_idx + 1'b1;
      end
      case (state)
        WAIT_START: cnt <= (uart_busy_i || start_to_hit) ? '0 : cnt + 1'b1;
        GAP: begin
          if (gap_done) begin
            cnt     <= '0;
            grant_o <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default:    cnt <= '0;
      endcase
    end
  end

`ifdef MM_UART_SCHED_DROP_CNT_EN
  logic [REQ_NR-1:0] drop_vec;
  logic [16:0]       drop_sum;

  always_comb begin
    drop_vec = din_update_i & pend & ~(take ? arb_gnt : '0);
    drop_sum = {1'b0, drop_cnt_o};
    for (int i = 0; i < REQ_NR; i++) begin
      drop_sum = drop_sum + 17'(drop_vec[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     drop_cnt_o <= '0;
    else if (clr_i) drop_cnt_o <= '0;
    else            drop_cnt_o <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_mm_uart_sched.sv
// tb/tb_mm_uart_sched.sv - directed self-checking bench for mm_uart_sched
module tb_mm_uart_sched;

  localparam int REQ_NR   = 4;
  localparam int CHAR_NR  = 13;
  localparam int GAP_CYC  = 20;
  localparam int START_TO = 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  clr_i = 1'b0;
  logic                  en_i = 1'b0;
  logic [REQ_NR*16-1:0]  din_bcd_i = '0;
  logic [REQ_NR-1:0]     din_update_i = '0;
  logic                  uart_busy_i = 1'b0;
  logic [CHAR_NR*8-1:0]  char_array_o;
  logic                  char_array_update_o;
  logic [REQ_NR-1:0]     grant_o;
  logic                  busy_o;
`ifdef MM_UART_SCHED_DROP_CNT_EN
  logic [15:0]           drop_cnt_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int strobe_cnt = 0;
  int snap;

  mm_uart_sched #(
    .REQ_NR(REQ_NR), .CHAR_NR(CHAR_NR), .GAP_CYC(GAP_CYC), .START_TO(START_TO)
  ) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .clr_i               (clr_i),
    .en_i                (en_i),
    .din_bcd_i           (din_bcd_i),
    .din_update_i        (din_update_i),
    .uart_busy_i         (uart_busy_i),
    .char_array_o        (char_array_o),
    .char_array_update_o (char_array_update_o),
    .grant_o             (grant_o),
    .busy_o              (busy_o)
`ifdef MM_UART_SCHED_DROP_CNT_EN
    ,
    .drop_cnt_o          (drop_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && char_array_update_o) strobe_cnt <= strobe_cnt + 1;
  end

  task automatic check(input string tag, input logic [103:0] obs, input logic [103:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input int ch, input logic [15:0] v);
    din_bcd_i[16*ch +: 16] = v;
    din_update_i[ch]       = 1'b1;
    step();
    din_update_i           = '0;
  endtask

  task automatic wait_strobe(input string tag);
    for (int i = 0; i < 300 && !char_array_update_o; i++) step();
    check({tag, "_strobe"}, 104'(char_array_update_o), 104'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300 && busy_o; i++) step();
    check({tag, "_idle"}, 104'(busy_o), 104'd0);
  endtask

  task automatic send_one(input string tag, input logic [3:0] g, input logic [103:0] m,
                          input int nbusy);
    wait_strobe(tag);
    check({tag, "_msg"}, char_array_o, m);
    check({tag, "_grant"}, 104'(grant_o), 104'(g));
    step();
    check({tag, "_strobe_1cyc"}, 104'(char_array_update_o), 104'd0);
    uart_busy_i = 1'b1;
    repeat (nbusy) step();
    uart_busy_i = 1'b0;
    wait_idle(tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 104'(busy_o), 104'd0);
    check("rst_grant", 104'(grant_o), 104'd0);
    check("rst_chars", char_array_o, 104'd0);
    check("rst_strobe", 104'(char_array_update_o), 104'd0);
    rst_n = 1'b1;
    en_i  = 1'b1;
    step();

    // single channel with full gap timing
    upd(0, 16'h1234);
    wait_strobe("single");
    check("single_msg", char_array_o, {"Vadc: 1.234V", 8'h0D});
    check("single_grant", 104'(grant_o), 104'h1);
    step();
    check("single_strobe_1cyc", 104'(char_array_update_o), 104'd0);
    uart_busy_i = 1'b1;
    repeat (50) step();
    uart_busy_i = 1'b0;
    repeat (GAP_CYC) step();
    check("gap_last_busy", 104'(busy_o), 104'd1);
    check("gap_last_grant", 104'(grant_o), 104'h1);
    check("gap_msg_stable", char_array_o, {"Vadc: 1.234V", 8'h0D});
    step();
    check("gap_exit_busy", 104'(busy_o), 104'd0);
    check("gap_exit_grant", 104'(grant_o), 104'd0);

    // busy never rises: start timeout then gap, with a non-BCD nibble
    upd(3, 16'h09A2);
    wait_strobe("noBusy");
    check("noBusy_msg", char_array_o, {"Viir: 0.9?2V", 8'h0D});
    check("noBusy_grant", 104'(grant_o), 104'h8);
    repeat (START_TO + GAP_CYC) step();
    check("noBusy_still_busy", 104'(busy_o), 104'd1);
    step();
    check("noBusy_idle", 104'(busy_o), 104'd0);

    // all four at once, served in round-robin order
    din_bcd_i    = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
    din_update_i = 4'b1111;
    step();
    din_update_i = '0;
    send_one("rr0", 4'b0001, {"Vadc: 1.111V", 8'h0D}, 5);
    send_one("rr1", 4'b0010, {"Vfir: 2.222V", 8'h0D}, 3);
    send_one("rr2", 4'b0100, {"Vrms: 3.333V", 8'h0D}, 7);
    send_one("rr3", 4'b1000, {"Viir: 4.444V", 8'h0D}, 2);
    din_bcd_i    = {16'h0003, 16'h0000, 16'h0000, 16'h0001};
    din_update_i = 4'b1001;
    step();
    din_update_i = '0;
    send_one("wrap0", 4'b0001, {"Vadc: 0.001V", 8'h0D}, 2);
    send_one("wrap3", 4'b1000, {"Viir: 0.003V", 8'h0D}, 2);

    // overwrite while another channel is sending
    upd(0, 16'h0007);
    wait_strobe("ovr_ch0");
    step();
    uart_busy_i = 1'b1;
    upd(2, 16'h0500);
    upd(2, 16'h0600);
    repeat (3) step();
    uart_busy_i = 1'b0;
    wait_idle("ovr_ch0");
    send_one("ovr_ch2", 4'b0100, {"Vrms: 0.600V", 8'h0D}, 2);
    snap = strobe_cnt;
    repeat (40) step();
    check("ovr_once", 104'(strobe_cnt), 104'(snap));
`ifdef MM_UART_SCHED_DROP_CNT_EN
    check("ovr_drop", 104'(drop_cnt_o), 104'd1);
`endif

    // clear during WAIT_DONE aborts and discards pending work
    upd(1, 16'h0321);
    wait_strobe("clr");
    step();
    uart_busy_i = 1'b1;
    upd(2, 16'h0999);
    step();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
    check("clr_busy", 104'(busy_o), 104'd0);
    check("clr_grant", 104'(grant_o), 104'd0);
    check("clr_chars", char_array_o, 104'd0);
    uart_busy_i = 1'b0;
    snap = strobe_cnt;
    repeat (40) step();
    check("clr_no_strobe", 104'(strobe_cnt), 104'(snap));

    // en_i low holds a pending channel back
    en_i = 1'b0;
    upd(1, 16'h0456);
    snap = strobe_cnt;
    repeat (10) step();
    check("en_hold", 104'(strobe_cnt), 104'(snap));
    en_i = 1'b1;
    check("en_pre_strobe", 104'(char_array_update_o), 104'd0);
    step();
    check("en_strobe", 104'(char_array_update_o), 104'd1);
    check("en_msg", char_array_o, {"Vfir: 0.456V", 8'h0D});
    check("en_grant", 104'(grant_o), 104'h2);
    step();
    uart_busy_i = 1'b1;
    step();
    uart_busy_i = 1'b0;
    wait_idle("en");

    // update and grant on the same edge: old value sent, new one stays pending
    en_i = 1'b0;
    upd(0, 16'h0111);
    en_i = 1'b1;
    din_bcd_i[15:0] = 16'h0222;
    din_update_i    = 4'b0001;
    step();
    din_update_i    = '0;
    check("same_strobe", 104'(char_array_update_o), 104'd1);
    check("same_old_msg", char_array_o, {"Vadc: 0.111V", 8'h0D});
    step();
    uart_busy_i = 1'b1;
    step();
    uart_busy_i = 1'b0;
    wait_idle("same_old");
    send_one("same_new", 4'b0001, {"Vadc: 0.222V", 8'h0D}, 2);
`ifdef MM_UART_SCHED_DROP_CNT_EN
    check("same_drop", 104'(drop_cnt_o), 104'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
